// File: rtl/sum_seq_pkg.sv
// Shared types and defaults for the digit-serial adder controller.
package sum_seq_pkg;

    localparam int N_DEFAULT = 1024;
    localparam int W_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width; a single-digit adder still needs one counter bit.
    function automatic int cnt_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/serial_add_digit.sv
// W-bit digit adder with the registered inter-digit carry.
module serial_add_digit #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);

    logic [W:0] total;
    logic       carry_q;
    logic       carry_d;

    assign total   = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, carry_q};
    assign sum_o   = total[W-1:0];
    assign carry_d = en_i ? total[W] : carry_q;
    assign carry_o = carry_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/sum_seq_ctrl.sv
// Digit-serial N-bit adder: accepts an operand pair, adds W bits per cycle,
// and holds the sum until the consumer takes it.
module sum_seq_ctrl
    import sum_seq_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c_out,
    output logic         carry_out,
    output logic         busy
);

    localparam int DIGITS = N / W;
    localparam int CW     = cnt_width(DIGITS);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  res_q, res_d;
    logic [N-1:0]  res_shift;
    logic [W-1:0]  sum_dig;
    logic          carry_clr;
    logic          carry_en;

    serial_add_digit #(.W(W)) u_digit (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (carry_clr),
        .en_i    (carry_en),
        .a_i     (a_q[W-1:0]),
        .b_i     (b_q[W-1:0]),
        .sum_o   (sum_dig),
        .carry_o (carry_out)
    );

    // Digits arrive LSB first, so each one enters at the top and slides down.
    if (W == N) begin : g_single_digit
        assign res_shift = sum_dig;
    end else begin : g_multi_digit
        assign res_shift = {sum_dig, res_q[N-1:W]};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        carry_clr = 1'b0;
        carry_en  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d       = a_in;
                    b_d       = b_in;
                    cnt_d     = '0;
                    carry_clr = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                carry_en = 1'b1;
                a_d      = a_q >> W;
                b_d      = b_q >> W;
                res_d    = res_shift;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath registers carry no reset; they are reloaded on every acceptance.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        res_q <= res_d;
    end

    assign c_out = res_q;

endmodule

// File: doc/sum_seq_ctrl.md
SUM_SEQ_CTRL -- requirements
Module: sum_seq_ctrl

Interface
REQ-001 Parameter N, 1024: operand and result width in bits.
REQ-002 Parameter W, 2: digit width in bits added per clock cycle; N SHALL be an integer multiple of W and W >= 1.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 in_valid  input  1: operand pair on a_in/b_in is offered.
REQ-006 in_ready  output  1: controller accepts an operand pair this cycle.
REQ-007 a_in  input  N: operand A, unsigned.
REQ-008 b_in  input  N: operand B, unsigned.
REQ-009 out_valid  output  1: c_out/carry_out hold a completed sum.
REQ-010 out_ready  input  1: consumer takes the result this cycle.
REQ-011 c_out  output  N: sum (a_in + b_in) mod 2^N.
REQ-012 carry_out  output  1: carry out of bit N-1.
REQ-013 busy  output  1: high while a sum is being computed (RUN state).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in RUN.
REQ-016 Acceptance: in IDLE with in_valid=1, SHALL latch a_in and b_in into operand shift registers, clear the digit carry, clear the digit counter, and go to RUN next cycle.
REQ-017 In RUN, each cycle SHALL feed the least-significant W bits of each operand register plus the carry register to the digit adder, shift both operand registers right by W, and shift the W-bit digit sum into the result register from the top.
REQ-018 The digit carry SHALL be registered each RUN cycle and SHALL be the only state carried between digits.
REQ-019 The digit counter SHALL count 0..N/W-1; on the RUN cycle where it equals N/W-1, the next state SHALL be DONE.
REQ-020 Latency: acceptance in cycle t SHALL give out_valid=1 first in cycle t+N/W+1 (t+513 for defaults).
REQ-021 In DONE, c_out and carry_out SHALL hold stable until out_valid && out_ready; that cycle SHALL transition to IDLE.
REQ-022 in_valid SHALL be ignored outside IDLE; a_in/b_in changes after acceptance SHALL NOT affect the result.
REQ-023 The carry SHALL be cleared at every acceptance so no carry leaks between consecutive sums.
REQ-024 c_out SHALL be driven from the result register only; it is don't-care while out_valid=0.

Reset
REQ-025 rst=1 SHALL force IDLE, in_ready=1 on the following cycle, out_valid=0, busy=0, carry register=0, counter=0, carry_out=0.
REQ-026 rst asserted during RUN or DONE SHALL abandon the operation with no out_valid pulse.
REQ-027 rst SHALL dominate in_valid and out_ready in the same cycle.

Structure
REQ-028 Package sum_seq_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default N and W constants.
REQ-029 One sub-module serial_add_digit SHALL implement the combinational W-bit digit adder plus the registered carry with a synchronous clear input; the controller SHALL hold the FSM, counter, and shift registers.
REQ-030 The counter width SHALL be clog2(N/W), minimum 1 bit.

Verification
REQ-031 N=8, W=2: a=0x01, b=0x01 -> c_out=0x02, carry_out=0, out_valid exactly 5 cycles after acceptance.
REQ-032 N=8, W=2: a=0xFF, b=0x01 -> c_out=0x00, carry_out=1; then a=0x00, b=0x00 -> c_out=0x00, carry_out=0 (carry cleared).
REQ-033 N=8, W=2: out_ready held 0 for 6 cycles in DONE -> c_out, carry_out, out_valid stable; in_ready=0 until the handshake cycle ends.
REQ-034 N=8, W=2: rst pulsed at the 2nd RUN cycle -> next cycle in_ready=1, busy=0, out_valid never asserted for that operation; a new sum 0x10+0x20 gives 0x30.
REQ-035 Defaults N=1024, W=2: 1000 random pairs, out_ready random -> c_out/carry_out match the reference 1025-bit sum; latency 513 cycles per acceptance.
REQ-036 N=8, W=1 and N=8, W=8: a=0xAA, b=0x55 -> c_out=0xFF, carry_out=0, latency 9 and 2 cycles respectively.
